alu_cmd_driver: RTL and testbench

- Sequential initiator for the combinational ALU.
- Accepts operation commands on a valid/ready stream and drives them onto the ALU's operand and opcode inputs.
- Captures the ALU result and status flags, and returns them on a valid/ready response stream.
- Keeps an accumulator so commands can chain on the previous result. Sits between a control/sequencer stage and the ALU instance.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 49 ++++
 rtl/alu_cmd_driver.sv | 155 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, driver FSM states and helpers.
package alu_pkg;

  localparam int unsigned ALU_NUM_OPS = 10;
  localparam int unsigned ALU_OP_W    = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_drv_state_t;

  // True when a raw opcode maps onto an implemented operation.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return op < ALU_OP_W'(ALU_NUM_OPS);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic, shift and compare with status flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  alu_op_t          opcode,
  output logic [WIDTH-1:0] result_c,
  output logic             zero_c,
  output logic             overflow_c,
  output logic             negative_c
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] sh;
  assign sh = in1[SHW-1:0];

  // Operation select; overflow is signed overflow and only meaningful for ADD/SUB.
  always_comb begin
    result_c   = '0;
    overflow_c = 1'b0;
    case (opcode)
      ALU_ADD: begin
        result_c   = in0 + in1;
        overflow_c = (in0[WIDTH-1] == in1[WIDTH-1]) && (result_c[WIDTH-1] != in0[WIDTH-1]);
      end
      ALU_SUB: begin
        result_c   = in0 - in1;
        overflow_c = (in0[WIDTH-1] != in1[WIDTH-1]) && (result_c[WIDTH-1] != in0[WIDTH-1]);
      end
      ALU_AND:  result_c = in0 & in1;
      ALU_OR:   result_c = in0 | in1;
      ALU_XOR:  result_c = in0 ^ in1;
      ALU_SLL:  result_c = in0 << sh;
      ALU_SRL:  result_c = in0 >> sh;
      ALU_SRA:  result_c = $signed(in0) >>> sh;
      ALU_SLT:  result_c = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      ALU_SLTU: result_c = {{(WIDTH-1){1'b0}}, (in0 < in1)};
      default:  result_c = '0;
    endcase
  end

  assign zero_c     = (result_c == '0);
  assign negative_c = result_c[WIDTH-1];

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequential initiator for the ALU: command stream in, captured result stream out,
// with an accumulator for chaining and a completed-operation counter.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ALU_OP_W-1:0]    cmd_opcode,
  input  logic [WIDTH-1:0]       cmd_in0,
  input  logic [WIDTH-1:0]       cmd_in1,
  input  logic                   cmd_use_acc,
  input  logic                   acc_clr,
  output logic [WIDTH-1:0]       alu_in0,
  output logic [WIDTH-1:0]       alu_in1,
  output alu_op_t                alu_opcode,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_overflow,
  input  logic                   alu_negative,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   resp_zero,
  output logic                   resp_overflow,
  output logic                   resp_negative,
  output logic                   resp_err,
  output logic [WIDTH-1:0]       acc,
  output logic [COUNT_WIDTH-1:0] op_count
);

  alu_drv_state_t state_q, state_d;

  logic [WIDTH-1:0]       in0_q, in0_d;
  logic [WIDTH-1:0]       in1_q, in1_d;
  alu_op_t                op_q, op_d;
  logic                   pend_err_q, pend_err_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic                   zero_q, zero_d;
  logic                   ovf_q, ovf_d;
  logic                   neg_q, neg_d;
  logic                   rerr_q, rerr_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] acc_eff;

  // Ready in IDLE, or in RESP when the current response is being consumed this cycle.
  assign cmd_ready = !rst && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
  assign accept    = cmd_valid && cmd_ready;
  assign acc_eff   = acc_clr ? '0 : acc_q;

  // Next-state, operand latch, response capture and accumulator update.
  always_comb begin
    state_d    = state_q;
    in0_d      = in0_q;
    in1_d      = in1_q;
    op_d       = op_q;
    pend_err_d = pend_err_q;
    res_d      = res_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    rerr_d     = rerr_q;
    acc_d      = acc_clr ? '0 : acc_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
        if (pend_err_q) begin
          res_d  = '0;
          zero_d = 1'b0;
          ovf_d  = 1'b0;
          neg_d  = 1'b0;
          rerr_d = 1'b1;
        end else begin
          res_d  = alu_result;
          zero_d = alu_zero;
          ovf_d  = alu_overflow;
          neg_d  = alu_negative;
          rerr_d = 1'b0;
          acc_d  = acc_clr ? '0 : alu_result;
          cnt_d  = cnt_q + COUNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Illegal commands leave the ALU ports untouched and only flag the response.
    if (accept) begin
      pend_err_d = !alu_op_legal(cmd_opcode);
      if (alu_op_legal(cmd_opcode)) begin
        in0_d = cmd_use_acc ? acc_eff : cmd_in0;
        in1_d = cmd_in1;
        op_d  = alu_op_t'(cmd_opcode);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in0_q      <= '0;
      in1_q      <= '0;
      op_q       <= ALU_ADD;
      pend_err_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      rerr_q     <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
      op_q       <= op_d;
      pend_err_q <= pend_err_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      neg_q      <= neg_d;
      rerr_q     <= rerr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign alu_in0       = in0_q;
  assign alu_in1       = in1_q;
  assign alu_opcode    = op_q;
  assign resp_valid    = (state_q == RESP);
  assign resp_result   = res_q;
  assign resp_zero     = zero_q;
  assign resp_overflow = ovf_q;
  assign resp_negative = neg_q;
  assign resp_err      = rerr_q;
  assign acc           = acc_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver wired to the real ALU: directed vector table plus
// hand-written chaining, backpressure, reset-abort and accumulator-clear sequences.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_in0, cmd_in1;
  logic        cmd_use_acc, acc_clr;
  logic [31:0] alu_in0, alu_in1;
  alu_op_t     alu_opcode;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow, alu_negative;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero, resp_overflow, resp_negative, resp_err;
  logic [31:0] acc;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_acc, exp_in0, exp_in1;
  logic [3:0]  exp_op;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  alu_cmd_driver #(.WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_in0(cmd_in0), .cmd_in1(cmd_in1), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_overflow(resp_overflow), .resp_negative(resp_negative),
    .resp_err(resp_err), .acc(acc), .op_count(op_count)
  );

  alu #(.WIDTH(32)) u_alu (
    .in0(alu_in0), .in1(alu_in1), .opcode(alu_opcode),
    .result_c(alu_result), .zero_c(alu_zero), .overflow_c(alu_overflow),
    .negative_c(alu_negative)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        use_acc;
    logic [31:0] res;
    logic [2:0]  znv;   // {zero, overflow, negative}
    logic        err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One command through accept/EXEC/RESP with resp_ready high.
  // clr_at: 0 = no clear, 1 = acc_clr in the accept cycle, 2 = acc_clr in the EXEC cycle.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic ua, input int clr_at, input logic [31:0] res,
                     input logic [2:0] znv, input logic er);
    int n;
    if (!er) begin
      exp_in0 = ua ? ((clr_at == 1) ? 32'h0 : exp_acc) : a;
      exp_in1 = b;
      exp_op  = op;
    end
    cmd_opcode  = op;
    cmd_in0     = a;
    cmd_in1     = b;
    cmd_use_acc = ua;
    acc_clr     = (clr_at == 1);
    resp_ready  = 1'b1;
    cmd_valid   = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    cmd_use_acc = 1'b0;
    acc_clr     = (clr_at == 2);
    @(negedge clk);
    chk("exec_resp_valid", 32'(resp_valid), 32'd0);
    chk("exec_alu_in0", alu_in0, exp_in0);
    chk("exec_alu_in1", alu_in1, exp_in1);
    chk("exec_alu_opcode", 32'(alu_opcode), 32'(exp_op));
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_result", resp_result, res);
    chk("resp_flags", 32'({resp_zero, resp_overflow, resp_negative}), 32'(znv));
    chk("resp_err", 32'(resp_err), 32'(er));
    if (!er) begin
      exp_acc = (clr_at == 2) ? 32'h0 : res;
      exp_cnt = exp_cnt + 16'd1;
    end
    chk("acc", acc, exp_acc);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    @(negedge clk);
    chk("resp_consumed", 32'(resp_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", resp_result, 32'h0);
    chk("rst_resp_flags", 32'({resp_zero, resp_overflow, resp_negative, resp_err}), 32'h0);
    chk("rst_acc", acc, 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    chk("rst_alu_in0", alu_in0, 32'h0);
    chk("rst_alu_in1", alu_in1, 32'h0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'(ALU_ADD));
  endtask

  initial begin
    vecs[0]  = '{4'd0, 32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 3'b011, 1'b0};
    vecs[1]  = '{4'd1, 32'h5,        32'h5,        1'b0, 32'h0,        3'b100, 1'b0};
    vecs[2]  = '{4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 3'b000, 1'b0};
    vecs[3]  = '{4'd3, 32'h1,        32'h2,        1'b0, 32'h3,        3'b000, 1'b0};
    vecs[4]  = '{4'd4, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0, 32'h0000FFFF, 3'b000, 1'b0};
    vecs[5]  = '{4'd5, 32'h1,        32'd31,       1'b0, 32'h80000000, 3'b001, 1'b0};
    vecs[6]  = '{4'd6, 32'h80000000, 32'd4,        1'b0, 32'h08000000, 3'b000, 1'b0};
    vecs[7]  = '{4'd7, 32'h80000000, 32'd4,        1'b0, 32'hF8000000, 3'b001, 1'b0};
    vecs[8]  = '{4'd8, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h1,        3'b000, 1'b0};
    vecs[9]  = '{4'd9, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        3'b100, 1'b0};
    vecs[10] = '{4'd1, 32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 3'b010, 1'b0};
    vecs[11] = '{4'd0, 32'hDEADBEEF, 32'h1,        1'b1, 32'h80000000, 3'b011, 1'b0};
    vecs[12] = '{4'hF, 32'h9,        32'h3,        1'b0, 32'h0,        3'b000, 1'b1};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_in0 = '0; cmd_in1 = '0;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; resp_ready = 1'b1;
    exp_acc = '0; exp_in0 = '0; exp_in1 = '0; exp_op = 4'd0; exp_cnt = '0;

    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Vector table: every opcode, flags, use_acc forwarding and an illegal opcode.
    for (int i = 0; i < 13; i++) begin
      run(vecs[i].op, vecs[i].in0, vecs[i].in1, vecs[i].use_acc, 0,
          vecs[i].res, vecs[i].znv, vecs[i].err);
    end

    // Back-to-back chain: ADD 3,4 then SLL acc<<2 with cmd_valid held high.
    cmd_opcode = 4'd0; cmd_in0 = 32'd3; cmd_in1 = 32'd4; cmd_use_acc = 1'b0;
    resp_ready = 1'b1; cmd_valid = 1'b1;
    chk("chain_ready0", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_opcode = 4'd5; cmd_in0 = 32'h0; cmd_in1 = 32'd2; cmd_use_acc = 1'b1;
    @(negedge clk);
    chk("chain_exec_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("chain_resp1_valid", 32'(resp_valid), 32'd1);
    chk("chain_resp1_result", resp_result, 32'd7);
    chk("chain_acc1", acc, 32'd7);
    chk("chain_resp_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_use_acc = 1'b0;
    @(negedge clk);
    chk("chain_exec2_valid", 32'(resp_valid), 32'd0);
    chk("chain_exec2_in0", alu_in0, 32'd7);
    chk("chain_exec2_op", 32'(alu_opcode), 32'(ALU_SLL));
    @(negedge clk);
    chk("chain_resp2_result", resp_result, 32'd28);
    exp_cnt = exp_cnt + 16'd2;
    chk("chain_acc2", acc, 32'd28);
    chk("chain_count", 32'(op_count), 32'(exp_cnt));
    @(negedge clk);
    chk("chain_idle", 32'(resp_valid), 32'd0);
    exp_acc = 32'd28; exp_in0 = 32'd7; exp_in1 = 32'd2; exp_op = 4'd5;

    // Backpressure: response must hold for 5 cycles with cmd_ready low.
    resp_ready = 1'b0;
    cmd_opcode = 4'd3; cmd_in0 = 32'h55; cmd_in1 = 32'hAA; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_result", resp_result, 32'hFF);
      chk("bp_flags", 32'({resp_zero, resp_overflow, resp_negative, resp_err}), 32'h0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("bp_released", 32'(resp_valid), 32'd0);
    exp_acc = 32'hFF; exp_cnt = exp_cnt + 16'd1;
    chk("bp_acc", acc, exp_acc);
    chk("bp_count", 32'(op_count), 32'(exp_cnt));

    // Reset asserted during EXEC aborts the command.
    cmd_opcode = 4'd0; cmd_in0 = 32'd1; cmd_in1 = 32'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    exp_acc = '0; exp_in0 = '0; exp_in1 = '0; exp_op = 4'd0; exp_cnt = '0;
    @(negedge clk);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);

    // Accumulator clear forwarding and clear-wins-over-capture.
    run(4'd0, 32'd10, 32'd0, 1'b0, 0, 32'd10, 3'b000, 1'b0);
    run(4'd0, 32'd0,  32'd5, 1'b1, 1, 32'd5,  3'b000, 1'b0);
    run(4'd0, 32'd2,  32'd3, 1'b0, 2, 32'd5,  3'b000, 1'b0);
    run(4'd0, 32'd0,  32'd1, 1'b1, 0, 32'd1,  3'b000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
